ir_burst_sequencer: RTL

- Upstream driver for the IR carrier (CTC) generator.
- Takes one code's carrier half-period plus a stream of mark/space duration pairs from the code-ROM reader over a valid/ready handshake.
- Drives the generator's reset, compare-value load, enable and forced-level inputs, so the LED emits carrier bursts of exact length separated by silent gaps.

---
 rtl/ir_burst_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ir_burst_sequencer.sv
// IR burst sequencer: drives the carrier (CTC) generator so the LED emits
// mark bursts of exact length separated by silent spaces, one code per start.
module ir_burst_sequencer #(
  parameter int CTC_WIDTH = 8,
  parameter int DUR_WIDTH = 16,
  parameter int PRESCALE  = 120
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic [CTC_WIDTH-1:0] carrier_value_in,
  input  logic                 pair_valid_in,
  output logic                 pair_ready_out,
  input  logic [DUR_WIDTH-1:0] on_time_in,
  input  logic [DUR_WIDTH-1:0] off_time_in,
  input  logic                 pair_last_in,
  output logic                 ctc_reset_out,
  output logic                 ctc_update_out,
  output logic [CTC_WIDTH-1:0] ctc_compare_value_out,
  output logic                 ctc_enable_out,
  output logic                 ctc_forced_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, FETCH, MARK, SPACE, DONE} state_t;

  state_t               state, state_next;
  logic [CTC_WIDTH-1:0] carrier_q;
  logic [DUR_WIDTH-1:0] off_q;
  logic                 last_q;
  logic [DUR_WIDTH-1:0] dur_cnt;
  logic [PW-1:0]        pre_cnt;
  logic                 accept;
  logic                 unit_tick;
  logic                 period_end;

  assign accept     = (state == FETCH) && pair_valid_in;
  assign unit_tick  = (pre_cnt == PRE_MAX);
  assign period_end = unit_tick && (dur_cnt == DUR_WIDTH'(1));

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_in) state_next = CLR;
      CLR:   state_next = LOAD;
      LOAD:  state_next = FETCH;
      FETCH: begin
        if (pair_valid_in) begin
          if (on_time_in != '0)       state_next = MARK;
          else if (off_time_in != '0) state_next = SPACE;
          else if (pair_last_in)      state_next = DONE;
          else                        state_next = FETCH;
        end
      end
      MARK: begin
        if (period_end) begin
          if (off_q != '0) state_next = SPACE;
          else if (last_q) state_next = DONE;
          else             state_next = FETCH;
        end
      end
      SPACE: if (period_end) state_next = last_q ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort_in) state_next = IDLE;
  end

  // Each mark/space lasts dur units of PRESCALE cycles; the prescaler
  // restarts on every entry so the first unit is a full one.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      carrier_q <= '0;
      off_q     <= '0;
      last_q    <= 1'b0;
      dur_cnt   <= '0;
      pre_cnt   <= '0;
    end else begin
      if ((state == IDLE) && start_in && !abort_in)
        carrier_q <= carrier_value_in;
      if (accept) begin
        off_q   <= off_time_in;
        last_q  <= pair_last_in;
        pre_cnt <= '0;
        dur_cnt <= (on_time_in != '0) ? on_time_in : off_time_in;
      end else if ((state == MARK) && period_end) begin
        pre_cnt <= '0;
        dur_cnt <= off_q;
      end else if ((state == MARK) || (state == SPACE)) begin
        if (unit_tick) begin
          pre_cnt <= '0;
          if (dur_cnt != '0) dur_cnt <= dur_cnt - DUR_WIDTH'(1);
        end else begin
          pre_cnt <= pre_cnt + PW'(1);
        end
      end
    end
  end

  assign pair_ready_out        = (state == FETCH);
  assign ctc_reset_out         = (state == CLR);
  assign ctc_update_out        = (state == LOAD);
  assign ctc_enable_out        = (state == MARK);
  assign ctc_forced_out        = 1'b0;
  assign busy_out              = (state != IDLE);
  assign done_out              = (state == DONE);
  assign ctc_compare_value_out = carrier_q;

endmodule
